rs_issue_queue: RTL and testbench

//  Parametrised out-of-order reservation station / issue queue between dispatch and the FUs.

---
 rtl/rs_issue_queue_if.sv | 47 ++++
 rtl/rs_issue_queue.sv | 172 +++++++++++++++++
 tb/tb_rs_issue_queue.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_queue_if.sv
// Dispatch / wakeup / issue bundle between the rename stage, the issue queue and the FUs.
interface rs_issue_queue_if #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DISP_W    = 2,
  parameter int unsigned NUM_FU    = 3,
  parameter int unsigned WAKE_W    = 3,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned ROB_W     = 4,
  parameter int unsigned PAYLOAD_W = 96
);
  localparam int unsigned FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                          flush;
  logic [DISP_W-1:0]             disp_valid;
  logic                          disp_ready;
  logic [DISP_W*FU_W-1:0]        disp_fu;
  logic [DISP_W*PREG_W-1:0]      disp_src1_tag;
  logic [DISP_W*PREG_W-1:0]      disp_src2_tag;
  logic [DISP_W-1:0]             disp_src1_rdy;
  logic [DISP_W-1:0]             disp_src2_rdy;
  logic [DISP_W*ROB_W-1:0]       disp_rob;
  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload;
  logic [WAKE_W-1:0]             wake_valid;
  logic [WAKE_W*PREG_W-1:0]      wake_tag;
  logic [NUM_FU-1:0]             fu_ready;
  logic [NUM_FU-1:0]             issue_valid;
  logic [NUM_FU*ROB_W-1:0]       issue_rob;
  logic [NUM_FU*PREG_W-1:0]      issue_src1_tag;
  logic [NUM_FU*PREG_W-1:0]      issue_src2_tag;
  logic [NUM_FU*PAYLOAD_W-1:0]   issue_payload;
  logic [CNT_W-1:0]              occupancy;

  modport master (
    output flush, disp_valid, disp_fu, disp_src1_tag, disp_src2_tag, disp_src1_rdy,
           disp_src2_rdy, disp_rob, disp_payload, wake_valid, wake_tag, fu_ready,
    input  disp_ready, issue_valid, issue_rob, issue_src1_tag, issue_src2_tag,
           issue_payload, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_fu, disp_src1_tag, disp_src2_tag, disp_src1_rdy,
           disp_src2_rdy, disp_rob, disp_payload, wake_valid, wake_tag, fu_ready,
    output disp_ready, issue_valid, issue_rob, issue_src1_tag, issue_src2_tag,
           issue_payload, occupancy
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Out-of-order issue queue: free-list allocation, tag wakeup, age-matrix oldest-ready select per FU.
module rs_issue_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DISP_W    = 2,
  parameter int unsigned NUM_FU    = 3,
  parameter int unsigned WAKE_W    = 3,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned ROB_W     = 4,
  parameter int unsigned PAYLOAD_W = 96
) (
  input logic              clk,
  input logic              reset,
  rs_issue_queue_if.slave  bus
);
  localparam int unsigned FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  logic [DEPTH-1:0]     valid_q, rdy1_q, rdy2_q;
  logic [FU_W-1:0]      fu_q   [DEPTH];
  logic [PREG_W-1:0]    src1_q [DEPTH];
  logic [PREG_W-1:0]    src2_q [DEPTH];
  logic [ROB_W-1:0]     rob_q  [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]     older_q [DEPTH];
  logic [DEPTH-1:0]     older_d [DEPTH];

  logic [CNT_W-1:0]     occ;
  logic [DEPTH-1:0]     alloc_en;
  logic [LANE_W-1:0]    alloc_lane [DEPTH];
  logic [NUM_FU-1:0]    sel_any;
  logic [IDX_W-1:0]     sel_idx [NUM_FU];
  logic [DEPTH-1:0]     freed;

  function automatic logic wake_hit(input logic [PREG_W-1:0]        tag,
                                    input logic [WAKE_W-1:0]        wv,
                                    input logic [WAKE_W*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_W; w++)
      if (wv[w] && (wt[w*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + CNT_W'(valid_q[i]);
  end

  assign bus.occupancy  = occ;
  assign bus.disp_ready = (occ <= CNT_W'(DEPTH - DISP_W));

  // Lane k is steered to the k-th lowest-index free entry.
  always_comb begin : p_alloc
    logic [CNT_W-1:0] nfree;
    nfree    = '0;
    alloc_en = '0;
    for (int i = 0; i < DEPTH; i++) alloc_lane[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) begin
        for (int k = 0; k < DISP_W; k++) begin
          if ((nfree == CNT_W'(k)) && bus.disp_valid[k] && bus.disp_ready && !bus.flush) begin
            alloc_en[i]   = 1'b1;
            alloc_lane[i] = LANE_W'(k);
          end
        end
        nfree = nfree + CNT_W'(1);
      end
    end
  end

  // A candidate wins when no other candidate for the same FU is older than it.
  always_comb begin : p_select
    logic [DEPTH-1:0] cand;
    logic             win;
    sel_any = '0;
    freed   = '0;
    for (int f = 0; f < NUM_FU; f++) sel_idx[f] = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++)
        cand[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i] & (fu_q[i] == FU_W'(f)) & bus.fu_ready[f];
      for (int i = 0; i < DEPTH; i++) begin
        win = cand[i];
        for (int j = 0; j < DEPTH; j++)
          if (cand[j] && older_q[j][i]) win = 1'b0;
        if (win) begin
          sel_any[f] = 1'b1;
          sel_idx[f] = IDX_W'(i);
          freed[i]   = 1'b1;
        end
      end
    end
  end

  // New entries are younger than every surviving entry; same-cycle lanes order by lane index.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (bus.flush)                      older_d[i][j] = 1'b0;
        else if (alloc_en[i] && alloc_en[j]) older_d[i][j] = alloc_lane[i] < alloc_lane[j];
        else if (alloc_en[i])               older_d[i][j] = 1'b0;
        else if (alloc_en[j])               older_d[i][j] = valid_q[i] & ~freed[i];
        else if (freed[i] || freed[j])      older_d[i][j] = 1'b0;
        else                                older_d[i][j] = older_q[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q            <= '0;
      rdy1_q             <= '0;
      rdy2_q             <= '0;
      bus.issue_valid    <= '0;
      bus.issue_rob      <= '0;
      bus.issue_src1_tag <= '0;
      bus.issue_src2_tag <= '0;
      bus.issue_payload  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fu_q[i]    <= '0;
        src1_q[i]  <= '0;
        src2_q[i]  <= '0;
        rob_q[i]   <= '0;
        pay_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      older_q <= older_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.flush) begin
          valid_q[i] <= 1'b0;
        end else if (alloc_en[i]) begin
          valid_q[i] <= 1'b1;
          for (int k = 0; k < DISP_W; k++) begin
            if (alloc_lane[i] == LANE_W'(k)) begin
              fu_q[i]   <= bus.disp_fu[k*FU_W +: FU_W];
              src1_q[i] <= bus.disp_src1_tag[k*PREG_W +: PREG_W];
              src2_q[i] <= bus.disp_src2_tag[k*PREG_W +: PREG_W];
              rob_q[i]  <= bus.disp_rob[k*ROB_W +: ROB_W];
              pay_q[i]  <= bus.disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
              rdy1_q[i] <= bus.disp_src1_rdy[k] | (bus.disp_src1_tag[k*PREG_W +: PREG_W] == '0)
                         | wake_hit(bus.disp_src1_tag[k*PREG_W +: PREG_W], bus.wake_valid, bus.wake_tag);
              rdy2_q[i] <= bus.disp_src2_rdy[k] | (bus.disp_src2_tag[k*PREG_W +: PREG_W] == '0)
                         | wake_hit(bus.disp_src2_tag[k*PREG_W +: PREG_W], bus.wake_valid, bus.wake_tag);
            end
          end
        end else if (freed[i]) begin
          valid_q[i] <= 1'b0;
        end else begin
          if (wake_hit(src1_q[i], bus.wake_valid, bus.wake_tag)) rdy1_q[i] <= 1'b1;
          if (wake_hit(src2_q[i], bus.wake_valid, bus.wake_tag)) rdy2_q[i] <= 1'b1;
        end
      end
      for (int f = 0; f < NUM_FU; f++) begin
        bus.issue_valid[f] <= sel_any[f] & ~bus.flush;
        if (sel_any[f] && !bus.flush) begin
          bus.issue_rob[f*ROB_W +: ROB_W]            <= rob_q[sel_idx[f]];
          bus.issue_src1_tag[f*PREG_W +: PREG_W]     <= src1_q[sel_idx[f]];
          bus.issue_src2_tag[f*PREG_W +: PREG_W]     <= src2_q[sel_idx[f]];
          bus.issue_payload[f*PAYLOAD_W +: PAYLOAD_W] <= pay_q[sel_idx[f]];
        end
      end
    end
  end

  // Dispatch against a full queue is dropped by the allocator; flag it as a protocol error.
  a_no_disp_when_full: assert property (@(posedge clk) disable iff (!reset)
    !((|bus.disp_valid) && !bus.disp_ready));

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue: vector table plus per-FU scoreboard of expected issues.
module tb_rs_issue_queue;
  localparam int unsigned DEPTH = 16, DISP_W = 2, NUM_FU = 3, WAKE_W = 3;
  localparam int unsigned PREG_W = 6, ROB_W = 4, PAYLOAD_W = 96, FU_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_issue_queue_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .NUM_FU(NUM_FU), .WAKE_W(WAKE_W),
                      .PREG_W(PREG_W), .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

  rs_issue_queue #(.DEPTH(DEPTH), .DISP_W(DISP_W), .NUM_FU(NUM_FU), .WAKE_W(WAKE_W),
                   .PREG_W(PREG_W), .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [ROB_W-1:0]     rob;
    logic [PREG_W-1:0]    s1;
    logic [PREG_W-1:0]    s2;
    logic [PAYLOAD_W-1:0] pay;
  } exp_t;

  typedef struct packed {
    logic [1:0] fu;  logic [3:0] rob;
    logic [5:0] s1;  logic r1;  logic [5:0] s2;  logic r2;
    logic wv;  logic [1:0] wl;  logic [5:0] wt;
    logic [2:0] fur;  logic exp_issue;
  } vec_t;

  exp_t exp_q [NUM_FU][$];
  vec_t vecs [8];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input int fu, rob, s1, r1, s2, r2, wv, wl, wt, fur, ex);
    vec_t v;
    v.fu = 2'(fu); v.rob = 4'(rob); v.s1 = 6'(s1); v.r1 = 1'(r1); v.s2 = 6'(s2); v.r2 = 1'(r2);
    v.wv = 1'(wv); v.wl = 2'(wl); v.wt = 6'(wt); v.fur = 3'(fur); v.exp_issue = 1'(ex);
    return v;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rnd_pay();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0;         bus.disp_valid = '0;     bus.disp_fu = '0;
    bus.disp_src1_tag = '0;   bus.disp_src2_tag = '0;  bus.disp_src1_rdy = '0;
    bus.disp_src2_rdy = '0;   bus.disp_rob = '0;       bus.disp_payload = '0;
    bus.wake_valid = '0;      bus.wake_tag = '0;
  endtask

  task automatic lane(input int k, input int fu, input int rob, input int s1, input bit r1,
                      input int s2, input bit r2, input bit push);
    exp_t e;
    e.rob = ROB_W'(rob); e.s1 = PREG_W'(s1); e.s2 = PREG_W'(s2); e.pay = rnd_pay();
    bus.disp_valid[k] = 1'b1;
    bus.disp_fu[k*FU_W +: FU_W]               = FU_W'(fu);
    bus.disp_rob[k*ROB_W +: ROB_W]            = e.rob;
    bus.disp_src1_tag[k*PREG_W +: PREG_W]     = e.s1;
    bus.disp_src2_tag[k*PREG_W +: PREG_W]     = e.s2;
    bus.disp_src1_rdy[k] = r1;
    bus.disp_src2_rdy[k] = r2;
    bus.disp_payload[k*PAYLOAD_W +: PAYLOAD_W] = e.pay;
    if (push) exp_q[fu].push_back(e);
  endtask

  task automatic wake(input int w, input int tag);
    bus.wake_valid[w] = 1'b1;
    bus.wake_tag[w*PREG_W +: PREG_W] = PREG_W'(tag);
  endtask

  // Scoreboard: every issue pulse must match the next expected entry for that FU.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (bus.issue_valid[f]) begin
          if (exp_q[f].size() == 0) begin
            chk($sformatf("unexpected_issue_fu%0d", f), 128'(bus.issue_valid[f]), 128'(0));
          end else begin
            e = exp_q[f].pop_front();
            chk($sformatf("issue_tags_fu%0d", f),
                128'({bus.issue_rob[f*ROB_W +: ROB_W], bus.issue_src1_tag[f*PREG_W +: PREG_W],
                      bus.issue_src2_tag[f*PREG_W +: PREG_W]}),
                128'({e.rob, e.s1, e.s2}));
            chk($sformatf("issue_payload_fu%0d", f),
                128'(bus.issue_payload[f*PAYLOAD_W +: PAYLOAD_W]), 128'(e.pay));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            fu rob s1 r1 s2 r2 wv wl wt fur ex
    vecs[0] = mkv(0, 3,  1, 1, 2, 1, 0, 0, 0, 7, 1);
    vecs[1] = mkv(1, 1,  5, 0, 6, 1, 0, 0, 0, 7, 0);
    vecs[2] = mkv(2, 7,  0, 0, 0, 0, 0, 0, 0, 7, 1);
    vecs[3] = mkv(0, 2,  3, 1, 9, 0, 1, 0, 9, 7, 1);
    vecs[4] = mkv(1, 4,  9, 0, 1, 1, 1, 1, 10, 7, 0);
    vecs[5] = mkv(2, 9,  4, 1, 33, 0, 1, 2, 33, 7, 1);
    vecs[6] = mkv(0, 10, 1, 1, 2, 1, 0, 0, 0, 6, 0);
    vecs[7] = mkv(1, 11, 1, 1, 2, 1, 0, 0, 0, 7, 1);

    reset = 1'b0;
    bus.fu_ready = '1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("reset_occ", 128'(bus.occupancy), 128'(0));
    chk("reset_disp_ready", 128'(bus.disp_ready), 128'(1));
    chk("reset_issue_valid", 128'(bus.issue_valid), 128'(0));

    // Single-lane vectors: dispatch, then expect issue (or not) one edge later.
    for (int v = 0; v < 8; v++) begin
      bus.fu_ready = vecs[v].fur;
      lane(0, int'(vecs[v].fu), int'(vecs[v].rob), int'(vecs[v].s1), vecs[v].r1,
           int'(vecs[v].s2), vecs[v].r2, vecs[v].exp_issue);
      if (vecs[v].wv) wake(int'(vecs[v].wl), int'(vecs[v].wt));
      step();
      idle_inputs();
      chk($sformatf("vec%0d_occ_e0", v), 128'(bus.occupancy), 128'(1));
      chk($sformatf("vec%0d_iv_e0", v), 128'(bus.issue_valid), 128'(0));
      step();
      chk($sformatf("vec%0d_occ_e1", v), 128'(bus.occupancy), vecs[v].exp_issue ? 128'(0) : 128'(1));
      chk($sformatf("vec%0d_iv_e1", v), 128'(bus.issue_valid[vecs[v].fu]), 128'(vecs[v].exp_issue));
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      bus.fu_ready = '1;
      chk($sformatf("vec%0d_occ_flush", v), 128'(bus.occupancy), 128'(0));
    end

    // Async reset while an issue pulse and a pending entry are live.
    lane(0, 0, 3, 1, 1, 2, 1, 0);
    lane(1, 1, 4, 7, 0, 8, 1, 0);
    step();
    idle_inputs();
    step();
    chk("mid_iv_before_reset", 128'(bus.issue_valid[0]), 128'(1));
    #1 reset = 1'b0;
    #1;
    chk("mid_reset_iv", 128'(bus.issue_valid), 128'(0));
    chk("mid_reset_occ", 128'(bus.occupancy), 128'(0));
    chk("mid_reset_disp_ready", 128'(bus.disp_ready), 128'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    step();

    // Two waiting entries woken by one broadcast issue oldest first, one per cycle.
    lane(0, 1, 5, 12, 0, 3, 1, 1);
    lane(1, 1, 6, 12, 0, 3, 1, 1);
    step();
    idle_inputs();
    chk("wake_occ2", 128'(bus.occupancy), 128'(2));
    step();
    chk("wake_no_issue", 128'(bus.issue_valid), 128'(0));
    wake(0, 12);
    step();
    idle_inputs();
    chk("wake_edge_iv", 128'(bus.issue_valid), 128'(0));
    step();
    chk("wake_first_iv", 128'(bus.issue_valid[1]), 128'(1));
    chk("wake_first_occ", 128'(bus.occupancy), 128'(1));
    step();
    chk("wake_second_iv", 128'(bus.issue_valid[1]), 128'(1));
    chk("wake_second_occ", 128'(bus.occupancy), 128'(0));
    step();
    chk("wake_drained_iv", 128'(bus.issue_valid), 128'(0));

    // Fill to full with FU2 blocked, then drain oldest-first.
    bus.fu_ready = 3'b011;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("fill_ready_%0d", c), 128'(bus.disp_ready), 128'(1));
      lane(0, 2, 2 * c, 1, 1, 2, 1, 1);
      lane(1, 2, 2 * c + 1, 1, 1, 2, 1, 1);
      step();
      idle_inputs();
    end
    chk("full_occ", 128'(bus.occupancy), 128'(DEPTH));
    chk("full_disp_ready", 128'(bus.disp_ready), 128'(0));
    step();
    step();
    chk("full_blocked_iv", 128'(bus.issue_valid), 128'(0));
    bus.fu_ready = '1;
    for (int n = 0; n < 16; n++) begin
      step();
      chk($sformatf("drain_iv_%0d", n), 128'(bus.issue_valid[2]), 128'(1));
      chk($sformatf("drain_occ_%0d", n), 128'(bus.occupancy), 128'(15 - n));
      chk($sformatf("drain_ready_%0d", n), 128'(bus.disp_ready), 128'((15 - n) <= 14));
    end
    step();
    chk("drain_done_iv", 128'(bus.issue_valid), 128'(0));

    // Flush with one entry selected and two lanes dispatching.
    lane(0, 0, 1, 1, 1, 2, 1, 0);
    step();
    idle_inputs();
    chk("flush_pre_occ", 128'(bus.occupancy), 128'(1));
    bus.flush = 1'b1;
    lane(0, 1, 2, 1, 1, 2, 1, 0);
    lane(1, 2, 3, 1, 1, 2, 1, 0);
    step();
    idle_inputs();
    chk("flush_occ", 128'(bus.occupancy), 128'(0));
    chk("flush_iv", 128'(bus.issue_valid), 128'(0));
    step();
    chk("flush_after_iv", 128'(bus.issue_valid), 128'(0));

    // A reused low-index entry must still be younger than an older high-index one.
    lane(0, 1, 1, 1, 1, 2, 1, 1);
    lane(1, 0, 2, 20, 0, 2, 1, 1);
    step();
    idle_inputs();
    step();
    chk("reuse_x_iv", 128'(bus.issue_valid[1]), 128'(1));
    lane(0, 0, 4, 20, 0, 2, 1, 1);
    step();
    idle_inputs();
    chk("reuse_occ2", 128'(bus.occupancy), 128'(2));
    wake(0, 20);
    step();
    idle_inputs();
    step();
    chk("reuse_y_iv", 128'(bus.issue_valid[0]), 128'(1));
    step();
    chk("reuse_w_iv", 128'(bus.issue_valid[0]), 128'(1));
    chk("reuse_occ0", 128'(bus.occupancy), 128'(0));
    step();

    for (int f = 0; f < NUM_FU; f++)
      chk($sformatf("scoreboard_empty_fu%0d", f), 128'(exp_q[f].size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
